// File: rtl/sram_cache_pkg.sv
// Shared types and sizing helpers for the 2-way write-through SRAM cache.
// Optional statistics counters are enabled with SRAM_CACHE_STATS_EN.
package sram_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WR,
    DONE
  } state_t;

  localparam int LINE_WORDS = 2;

  function automatic int INDEX_W(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int TAG_W(input int sram_aw, input int sets);
    return sram_aw - $clog2(LINE_WORDS) - $clog2(sets);
  endfunction

endpackage

// File: rtl/sram_cache_ctrl_way.sv
// One cache way: valid, tag and 2-word line storage indexed by set.
// Provides lookup, whole-line fill and single-word update.
module cache_way #(
  parameter int SETS   = 64,
  parameter int DATA_W = 32,
  parameter int IW     = 6,
  parameter int TW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     index,
  input  logic [TW-1:0]     tag,
  input  logic              word_sel,
  input  logic              fill_en,
  input  logic [DATA_W-1:0] fill_w0,
  input  logic [DATA_W-1:0] fill_w1,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              hit,
  output logic              vld,
  output logic [DATA_W-1:0] rd_word
);

  logic [SETS-1:0]   valid;
  logic [TW-1:0]     tags [SETS];
  logic [DATA_W-1:0] w0   [SETS];
  logic [DATA_W-1:0] w1   [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until valid is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index] <= tag;
      w0[index]   <= fill_w0;
      w1[index]   <= fill_w1;
    end else if (wr_en) begin
      if (word_sel) w1[index] <= wr_data;
      else          w0[index] <= wr_data;
    end
  end

  assign vld     = valid[index];
  assign hit     = vld && (tags[index] == tag);
  assign rd_word = word_sel ? w1[index] : w0[index];

endmodule

// File: rtl/sram_cache_ctrl.sv
// 2-way write-through, read-allocate data cache in front of an async SRAM.
// Define SRAM_CACHE_STATS_EN to add the hit_cnt/miss_cnt outputs.
module sram_cache_ctrl
  import sram_cache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SRAM_AW   = 17,
  parameter int SETS      = 64,
  parameter int SRAM_WAIT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  output logic               SRAM_WE_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0]  SRAM_DQ
`ifdef SRAM_CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int IW = INDEX_W(SETS);
  localparam int TW = TAG_W(SRAM_AW, SETS);
  localparam int CW = $clog2(SRAM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(SRAM_WAIT - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [SETS-1:0]   lru;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;

  logic [SRAM_AW-1:0] waddr;
  logic               wsel;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      tag;
  logic               unused_addr;

  assign waddr       = addr[SRAM_AW+1:2];
  assign wsel        = addr[2];
  assign idx         = addr[3 +: IW];
  assign tag         = addr[SRAM_AW+1 -: TW];
  assign unused_addr = ^{addr[ADDR_W-1:SRAM_AW+2], addr[1:0]};

  logic              hit0, hit1, v0, v1;
  logic [DATA_W-1:0] rw0, rw1;
  logic              any_hit, rd_req, in_idle, last, fill, victim;

  assign any_hit = hit0 | hit1;
  assign rd_req  = mem_r_en & ~mem_w_en;
  assign in_idle = (state == IDLE);
  assign last    = (cnt == LAST);
  assign fill    = (state == RD1) && last;
  assign victim  = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx]);

  cache_way #(
    .SETS(SETS), .DATA_W(DATA_W), .IW(IW), .TW(TW)
  ) u_way0 (
    .clk(clk), .rst(rst), .index(idx), .tag(tag),
    .word_sel(wsel),
    .fill_en(fill && !victim),
    .fill_w0(buf0), .fill_w1(SRAM_DQ),
    .wr_en(in_idle && mem_w_en && hit0),
    .wr_data(wdata),
    .hit(hit0), .vld(v0), .rd_word(rw0)
  );

  cache_way #(
    .SETS(SETS), .DATA_W(DATA_W), .IW(IW), .TW(TW)
  ) u_way1 (
    .clk(clk), .rst(rst), .index(idx), .tag(tag),
    .word_sel(wsel),
    .fill_en(fill && victim),
    .fill_w0(buf0), .fill_w1(SRAM_DQ),
    .wr_en(in_idle && mem_w_en && hit1),
    .wr_data(wdata),
    .hit(hit1), .vld(v1), .rd_word(rw1)
  );

  // Hits must complete in the request cycle, so ready/rdata stay combinational.
  always_comb begin
    ready = 1'b0;
    rdata = '0;
    unique case (1'b1)
      !rst: ready = 1'b1;
      rst && state == DONE: begin
        ready = 1'b1;
        rdata = wsel ? buf1 : buf0;
      end
      rst && in_idle: begin
        ready = !(mem_w_en || (rd_req && !any_hit));
        if (rd_req && any_hit) rdata = hit1 ? rw1 : rw0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lru       <= '0;
      buf0      <= '0;
      buf1      <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_w_en) begin
            state     <= WR;
            SRAM_WE_N <= 1'b0;
            SRAM_ADDR <= waddr;
            if (any_hit) lru[idx] <= ~hit1;
          end else if (rd_req && !any_hit) begin
            state     <= RD0;
            SRAM_ADDR <= {waddr[SRAM_AW-1:1], 1'b0};
          end else if (rd_req) begin
            lru[idx] <= ~hit1;
          end
        end
        RD0: begin
          if (last) begin
            state        <= RD1;
            cnt          <= '0;
            buf0         <= SRAM_DQ;
            SRAM_ADDR[0] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD1: begin
          if (last) begin
            state    <= DONE;
            cnt      <= '0;
            buf1     <= SRAM_DQ;
            lru[idx] <= ~victim;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (last) begin
            state     <= DONE;
            cnt       <= '0;
            SRAM_WE_N <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SRAM_DQ = SRAM_WE_N ? {DATA_W{1'bz}} : wdata;

`ifdef SRAM_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (in_idle && rd_req) begin
      if (any_hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + 1'b1;
      if (!any_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`else
  // Statistics hardware is absent in this build.
`endif

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// Bench for sram_cache_ctrl: directed table, reset-abort case, random ops.
// Build with SRAM_CACHE_STATS_EN to also check the statistics counters.
module tb_sram_cache_ctrl;

  localparam int W    = 5;
  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        SRAM_WE_N;
  logic [16:0] SRAM_ADDR;
  wire  [31:0] SRAM_DQ;
`ifdef SRAM_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  sram_cache_ctrl #(
    .ADDR_W(32), .DATA_W(32), .SRAM_AW(17), .SETS(SETS), .SRAM_WAIT(W)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ(SRAM_DQ)
`ifdef SRAM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [16:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Behavioural SRAM: unwritten words read back as init_word(address).
  logic [31:0] sram    [0:(1<<17)-1];
  bit          wr_flag [0:(1<<17)-1];
  logic [31:0] model_q;

  assign model_q = wr_flag[SRAM_ADDR] ? sram[SRAM_ADDR] : init_word(SRAM_ADDR);
  assign SRAM_DQ = (SRAM_WE_N && rst) ? model_q : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (rst && !SRAM_WE_N) begin
      sram[SRAM_ADDR]    <= SRAM_DQ;
      wr_flag[SRAM_ADDR] <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: memory contents plus per-set tags/valid/LRU of the cache.
  logic [31:0] ref_mem [int];
  bit          rv [SETS][2];
  int          rt [SETS][2];
  int          rl [SETS];

  function automatic logic [31:0] ref_rd(input int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(17'(wa));
  endfunction

  function automatic void ref_reset();
    for (int s = 0; s < SETS; s++) begin
      rv[s][0] = 0;
      rv[s][1] = 0;
      rl[s]    = 0;
    end
  endfunction

  // Returns the expected number of stalled cycles for one request.
  function automatic int ref_op(input bit we, input logic [31:0] a,
                                input logic [31:0] wd);
    int wa   = int'(a[18:2]);
    int line = wa / 2;
    int s    = line % SETS;
    int t    = line / SETS;
    int way  = -1;
    for (int w = 0; w < 2; w++)
      if (rv[s][w] && rt[s][w] == t) way = w;
    if (we) begin
      ref_mem[wa] = wd;
      if (way >= 0) rl[s] = 1 - way;
      return W;
    end
    if (way >= 0) begin
      rl[s] = 1 - way;
      return 0;
    end
    way = !rv[s][0] ? 0 : (!rv[s][1] ? 1 : rl[s]);
    rv[s][way] = 1;
    rt[s][way] = t;
    rl[s] = 1 - way;
    return 2 * W;
  endfunction

  logic [16:0] tr_a  [$];
  logic        tr_we [$];
  logic [31:0] tr_dq [$];

  task automatic apply(input bit we, input logic [31:0] a,
                       input logic [31:0] wd, output int stall,
                       output logic [31:0] rd);
    int guard = 0;
    @(negedge clk);
    mem_w_en = we;
    mem_r_en = !we;
    addr     = a;
    wdata    = wd;
    stall    = 0;
    tr_a.delete();
    tr_we.delete();
    tr_dq.delete();
    #1;
    while (!ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
      if (!ready) begin
        stall++;
        tr_a.push_back(SRAM_ADDR);
        tr_we.push_back(SRAM_WE_N);
        tr_dq.push_back(SRAM_DQ);
      end
    end
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: ready stuck at 0 for addr %h", a);
    end
    rd = rdata;
    @(posedge clk);
    #1;
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    ref_reset();
  endtask

  typedef struct {
    bit          rst_first;
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    int          stall;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  initial begin
    int          st, good, dummy;
    logic [31:0] rd;
    ref_reset();

    vt.push_back('{0, 0, 32'h400, 0, 10, init_word(17'h100)});
    vt.push_back('{0, 0, 32'h404, 0, 0, init_word(17'h101)});
    vt.push_back('{0, 1, 32'h400, 32'hDEAD_BEEF, 5, 0});
    vt.push_back('{0, 0, 32'h400, 0, 0, 32'hDEAD_BEEF});
    vt.push_back('{0, 1, 32'h800, 32'h1234_5678, 5, 0});
    vt.push_back('{0, 0, 32'h800, 0, 10, 32'h1234_5678});
    vt.push_back('{1, 0, 32'h000, 0, 10, init_word(17'h000)});
    vt.push_back('{0, 0, 32'h200, 0, 10, init_word(17'h080)});
    vt.push_back('{0, 0, 32'h000, 0, 0, init_word(17'h000)});
    vt.push_back('{0, 0, 32'h400, 0, 10, 32'hDEAD_BEEF});
    vt.push_back('{0, 0, 32'h000, 0, 0, init_word(17'h000)});
    vt.push_back('{0, 0, 32'h200, 0, 10, init_word(17'h080)});

    #22;
    check("rst_ready", 32'(ready), 1);
    check("rst_rdata", rdata, 0);
    check("rst_we_n", 32'(SRAM_WE_N), 1);
    check("rst_addr", 32'(SRAM_ADDR), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_ready", 32'(ready), 1);

    foreach (vt[i]) begin
      if (vt[i].rst_first) pulse_reset();
      dummy = ref_op(vt[i].we, vt[i].a, vt[i].wd);
      apply(vt[i].we, vt[i].a, vt[i].wd, st, rd);
      check($sformatf("vec%0d_stall", i), 32'(st), 32'(vt[i].stall));
      if (!vt[i].we) check($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      if (i == 0) begin
        good = 0;
        foreach (tr_a[k])
          if (tr_a[k] == ((k < W) ? 17'h100 : 17'h101) && tr_we[k]) good++;
        check("fill_addr_seq", 32'(good), 2 * W);
      end
      if (i == 1) check("hit_addr_hold", 32'(SRAM_ADDR), 32'h101);
      if (i == 2) begin
        good = 0;
        foreach (tr_a[k])
          if (!tr_we[k] && tr_dq[k] == 32'hDEAD_BEEF && tr_a[k] == 17'h100)
            good++;
        check("write_cycles", 32'(good), W);
      end
      if (i == 3) check("hit_no_sram", 32'(SRAM_ADDR), 32'h100);
    end
`ifdef SRAM_CACHE_STATS_EN
    check("hit_cnt", hit_cnt, 2);
    check("miss_cnt", miss_cnt, 4);
`endif

    // Reset during the fourth stalled cycle of a read miss.
    @(negedge clk);
    mem_r_en = 1'b1;
    addr     = 32'h1000;
    repeat (4) @(negedge clk);
    #1;
    check("abort_pre_ready", 32'(ready), 0);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 1);
    check("abort_we_n", 32'(SRAM_WE_N), 1);
    check("abort_addr", 32'(SRAM_ADDR), 0);
    check("abort_rdata", rdata, 0);
    mem_r_en = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    ref_reset();
    dummy = ref_op(1'b0, 32'h1000, 0);
    apply(1'b0, 32'h1000, 0, st, rd);
    check("abort_retry_stall", 32'(st), 2 * W);
    check("abort_retry_rdata", rd, ref_rd(32'h1000 >> 2));

    pulse_reset();
    for (int n = 0; n < 300; n++) begin
      int          r  = int'($urandom_range(0, 9));
      logic [31:0] a  = (32'($urandom_range(0, 3)) << 9)
                      | (32'($urandom_range(0, 3)) << 3)
                      | (32'($urandom_range(0, 1)) << 2);
      logic [31:0] wd = $urandom;
      int          es;
      logic [31:0] er;
      if (r == 0) begin
        @(negedge clk);
        #1;
        check("rnd_idle_ready", 32'(ready), 1);
        check("rnd_idle_we_n", 32'(SRAM_WE_N), 1);
      end else begin
        er = ref_rd(int'(a[18:2]));
        es = ref_op(r <= 3, a, wd);
        apply(r <= 3, a, wd, st, rd);
        check($sformatf("rnd%0d_stall", n), 32'(st), 32'(es));
        if (r > 3) check($sformatf("rnd%0d_rdata", n), rd, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
